spi_slave: RTL and testbench
============================

# spi_slave

SPI responder (mode 0, CPOL=0/CPHA=0) that lets an external master read and write bytes over the board's SPI pins. Fabric logic exchanges bytes through a valid/ready transmit port and a one-cycle-pulse receive port. SPI inputs are oversampled and synchronized into the `clk50m` domain, so the block has no second clock. It sits beside the UART/GPIO glue in the top level.

## Interface
- `DATA_W`, 8: bits per SPI word.
- `SYNC_STAGES`, 2: synchronizer flops on `spi_sclk`, `spi_ss` and `spi_mosi`; minimum 2.
- `IDLE_WORD`, all ones: word shifted out when no transmit data is pending (underrun).
- `clk50m` input 1: system clock; all state is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `spi_ss` input 1: active-low chip select from the master.
- `spi_sclk` input 1: serial clock from the master.
- `spi_mosi` input 1: master-to-responder data.
- `spi_miso` output 1: responder-to-master data.
- `spi_miso_oe` output 1: miso output enable; 1 only while selected.
- `tx_data` input DATA_W: next word to send.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: transmit holding register is empty.
- `rx_data` output DATA_W: last complete received word; held until the next word completes.
- `rx_valid` output 1: one-cycle pulse when `rx_data` updates.
- `busy` output 1: selected; a transfer is in progress.

## Operation
- Reset values: `spi_miso`=1, `spi_miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `busy`=0, state IDLE, bit count 0, holding register empty.
- Transmit holding register: one entry. Loads on `tx_valid && tx_ready`, which clears `tx_ready` on the next cycle. Accepted in any state.
- State IDLE -> SHIFT on synchronized ss falling edge:
  - copy holding register into tx shift register, or `IDLE_WORD` if empty;
  - mark holding register empty;
  - bit count 0; `spi_miso_oe`=1; drive first bit (MSB).
- SHIFT, synchronized sclk rising edge: shift sampled mosi into rx shift register; increment bit count.
- When bit count reaches DATA_W: next cycle `rx_data` = assembled word, `rx_valid`=1; bit count wraps to 0.
- SHIFT, sclk falling edge:
  - bit count ≠ 0: present next tx bit;
  - bit count = 0 (word boundary): reload tx shift register from holding register (or `IDLE_WORD`) and present its first bit.
- Reload samples the registered holding-register state. A `tx_valid` handshake in the same cycle as a reload is not sent in the current word; that data is kept for the next word.
- SHIFT -> IDLE on synchronized ss rising edge, in any bit position:
  - partial rx word discarded, no `rx_valid`;
  - partially sent tx word is lost;
  - holding register contents retained;
  - `spi_miso_oe`=0, `spi_miso`=1.
- Simultaneous sclk and ss edges in one cycle: the ss edge wins.
- New receive words overwrite `rx_data` without backpressure; the consumer must take each word on its `rx_valid` pulse.

## Timing
- Input path latency: `SYNC_STAGES`+1 clk50m cycles from pin to internal edge detection.
- Maximum `spi_sclk` is clk50m/8 (6.25 MHz); high and low phases must each be at least 4 cycles.
- `spi_miso` valid `SYNC_STAGES`+2 cycles after `spi_ss` falls. The master must wait at least 80 ns (4 cycles) before the first sclk rising edge.
- After an sclk falling edge at the pin, `spi_miso` changes within `SYNC_STAGES`+2 cycles.
- `rx_valid` is asserted `SYNC_STAGES`+2 cycles after the last sclk rising edge of a word.
- `busy` follows the synchronized ss with 1 cycle of latency.

## Configuration
- `SPI_SLAVE_LSB_FIRST_EN` defined: both rx and tx shift registers work LSB first; the first bit driven is `tx_data[0]`.
- Macro undefined: MSB first. This is the default and matches the board's SPI flash master.

## Structure
- Package `spi_slave_pkg` holds:
  - state enum (IDLE, SHIFT);
  - default `DATA_W`, `SYNC_STAGES` and `IDLE_WORD` constants;
  - bit-counter width function (clog2 of DATA_W+1).
- Sub-module `spi_sync_edge`: a `SYNC_STAGES` synchronizer plus rise/fall pulse detector with async active-low reset. Instantiated for sclk and ss. mosi uses the synchronizer only.

## Test plan
- Preload `tx_data`=0xA5; master sends 0x3C at 1 MHz -> miso shifts out 10100101; one `rx_valid` pulse with `rx_data`=0x3C; `tx_ready` returns to 1 at ss fall.
- Empty holding register; master sends 0x12 -> miso carries 0xFF; `rx_data`=0x12.
- Three-word burst with words 0x01, 0x02, 0x03 loaded back-to-back via the handshake; master sends 0xF0, 0x0F, 0x55 -> miso 0x01, 0x02, 0x03; three `rx_valid` pulses in order.
- ss deasserted after 5 sclk edges -> no `rx_valid`; `spi_miso_oe`=0 and `spi_miso`=1 after sync latency; the next full transfer works normally.
- `rst_n` pulsed low mid-word -> all outputs return to their reset values immediately; a subsequent transfer is correct.
- `SPI_SLAVE_LSB_FIRST_EN` build, `tx_data`=0x01, master sends 0x80 LSB-first -> first miso bit 1; `rx_data`=0x80.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and defaults for the SPI responder.
package spi_slave_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam logic [DEF_DATA_W-1:0] DEF_IDLE_WORD = '1;

  // Wide enough to hold the value DATA_W itself, not just DATA_W-1.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer, and a synchronizer with rise/fall pulse detection.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk50m,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) chain <= {STAGES{RST_VAL}};
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];
endmodule

module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk50m,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic lvl;
  logic prev;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(RST_VAL)) u_sync (
    .clk50m (clk50m),
    .rst_n  (rst_n),
    .d      (d),
    .q      (lvl)
  );

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) prev <= RST_VAL;
    else        prev <= lvl;
  end

  assign rise = lvl & ~prev;
  assign fall = ~lvl & prev;
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder oversampled in the clk50m domain, one-entry tx holding register.
// Define SPI_SLAVE_LSB_FIRST_EN for LSB-first shifting; default is MSB first.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic [DATA_W-1:0] IDLE_WORD = {DATA_W{1'b1}}
) (
  input  logic              clk50m,
  input  logic              rst_n,
  input  logic              spi_ss,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);
  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic ss_rise, ss_fall, sclk_rise, sclk_fall, mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk50m (clk50m), .rst_n (rst_n), .d (spi_ss), .rise (ss_rise), .fall (ss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk50m (clk50m), .rst_n (rst_n), .d (spi_sclk), .rise (sclk_rise), .fall (sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk50m (clk50m), .rst_n (rst_n), .d (spi_mosi), .q (mosi_s)
  );

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_shift, rx_shift, hold_dat;
  logic              hold_full;

  logic [DATA_W-1:0] load_word, load_rest, tx_rest, rx_next;
  logic              load_bit, tx_bit;

  assign load_word = hold_full ? hold_dat : IDLE_WORD;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign load_bit  = load_word[0];
  assign load_rest = load_word >> 1;
  assign tx_bit    = tx_shift[0];
  assign tx_rest   = tx_shift >> 1;
  assign rx_next   = {mosi_s, rx_shift[DATA_W-1:1]};
`else
  assign load_bit  = load_word[DATA_W-1];
  assign load_rest = load_word << 1;
  assign tx_bit    = tx_shift[DATA_W-1];
  assign tx_rest   = tx_shift << 1;
  assign rx_next   = {rx_shift[DATA_W-2:0], mosi_s};
`endif

  assign tx_ready = ~hold_full;

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      hold_dat    <= '0;
      hold_full   <= 1'b0;
      spi_miso    <= 1'b1;
      spi_miso_oe <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state       <= SHIFT;
            busy        <= 1'b1;
            spi_miso_oe <= 1'b1;
            spi_miso    <= load_bit;
            tx_shift    <= load_rest;
            hold_full   <= 1'b0;
            bit_cnt     <= '0;
          end
        end
        SHIFT: begin
          if (bit_cnt == CNT_FULL) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
            bit_cnt  <= '0;
          end
          // ss edge takes priority over any sclk edge seen in the same cycle.
          if (ss_rise) begin
            state       <= IDLE;
            busy        <= 1'b0;
            spi_miso_oe <= 1'b0;
            spi_miso    <= 1'b1;
            bit_cnt     <= '0;
          end else if (sclk_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + 1'b1;
          end else if (sclk_fall) begin
            if (bit_cnt == '0) begin
              spi_miso  <= load_bit;
              tx_shift  <= load_rest;
              hold_full <= 1'b0;
            end else begin
              spi_miso <= tx_bit;
              tx_shift <= tx_rest;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // A handshake coinciding with a reload lands after it, so it waits for the next word.
      if (tx_valid && !hold_full) begin
        hold_dat  <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// Randomized self-checking bench for spi_slave with a transaction-level holding-register model.
module tb_spi_slave;
  localparam int SYNC = 2;

  logic       clk50m = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_ss = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       spi_miso, spi_miso_oe, tx_ready, rx_valid, busy;
  logic [7:0] rx_data;

  int vectors = 0;
  int miscompares = 0;

  always #10 clk50m = ~clk50m;

  spi_slave dut (
    .clk50m (clk50m), .rst_n (rst_n), .spi_ss (spi_ss), .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi), .spi_miso (spi_miso), .spi_miso_oe (spi_miso_oe),
    .tx_data (tx_data), .tx_valid (tx_valid), .tx_ready (tx_ready),
    .rx_data (rx_data), .rx_valid (rx_valid), .busy (busy)
  );

  // Model: holding register is a one-deep slot consumed at ss fall and every word boundary.
  logic       hold_vld = 1'b0;
  logic [7:0] hold_dat = 8'h00;
  logic [7:0] mosi_q[$], got_q[$], exp_q[$], rx_q[$];
  logic       oe_seen, ready_seen, busy_seen;

  always @(negedge clk50m) if (rx_valid) rx_q.push_back(rx_data);

  function automatic int bit_idx(input int b);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return b;
`else
    return 7 - b;
`endif
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk50m);
  endtask

  task automatic take_hold(output logic [7:0] w);
    if (hold_vld) begin
      w = hold_dat;
      hold_vld = 1'b0;
    end else begin
      w = 8'hFF;
    end
  endtask

  task automatic load(input logic [7:0] d);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk50m);
      n++;
    end
    if (tx_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL load_timeout tx_ready=%b required 1", tx_ready);
      return;
    end
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk50m);
    tx_valid = 1'b0;
    hold_vld = 1'b1;
    hold_dat = d;
  endtask

  task automatic spi_xfer(input int nwords, input int half, input int abort_edges);
    logic [7:0] w, g, e;
    int edges;
    bit stop;
    edges = 0;
    stop = 0;
    got_q.delete();
    exp_q.delete();
    @(negedge clk50m);
    spi_ss = 1'b0;
    take_hold(e);
    exp_q.push_back(e);
    for (int wi = 0; wi < nwords && !stop; wi++) begin
      w = mosi_q[wi];
      g = 8'h00;
      for (int b = 0; b < 8; b++) begin
        spi_mosi = w[bit_idx(b)];
        wait_cyc(half);
        if (wi == 0 && b == 0) begin
          oe_seen = spi_miso_oe;
          ready_seen = tx_ready;
          busy_seen = busy;
        end
        g[bit_idx(b)] = spi_miso;
        spi_sclk = 1'b1;
        edges++;
        if (edges == abort_edges) begin stop = 1; break; end
        wait_cyc(half);
        spi_sclk = 1'b0;
        edges++;
        if (edges == abort_edges) begin stop = 1; break; end
        if (b == 7) begin
          take_hold(e);
          exp_q.push_back(e);
        end
      end
      if (!stop) got_q.push_back(g);
    end
    if (!stop) wait_cyc(half);
    spi_sclk = 1'b0;
    spi_ss = 1'b1;
    wait_cyc(SYNC + 4);
  endtask

  task automatic test_reset;
    if (spi_miso !== 1'b1) begin miscompares++; $display("FAIL reset_miso got %b want 1", spi_miso); end
    if (spi_miso_oe !== 1'b0) begin miscompares++; $display("FAIL reset_oe got %b want 0", spi_miso_oe); end
    if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
    if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors += 6;
  endtask

  // One full single-word transfer with optional preload, checked against the model.
  task automatic run_single(input string name, input bit pre, input logic [7:0] txd,
                            input logic [7:0] rxd, input int half);
    if (pre) load(txd);
    mosi_q.delete();
    mosi_q.push_back(rxd);
    rx_q.delete();
    spi_xfer(1, half, 0);
    vectors += 5;
    if (oe_seen !== 1'b1 || busy_seen !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_oe_busy got oe=%b busy=%b want 1/1", name, oe_seen, busy_seen);
    end
    if (ready_seen !== 1'b1) begin
      miscompares++; $display("FAIL %s_tx_ready_after_ss got %b want 1", name, ready_seen);
    end
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      miscompares++;
      $display("FAIL %s_miso got %h want %h", name, (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0]);
    end
    if (rx_q.size() != 1 || rx_q[0] !== rxd) begin
      miscompares++;
      $display("FAIL %s_rx got n=%0d %h want n=1 %h", name, rx_q.size(),
               (rx_q.size() > 0) ? rx_q[0] : 8'hxx, rxd);
    end
    if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle_after got oe=%b miso=%b busy=%b want 0/1/0", name, spi_miso_oe, spi_miso, busy);
    end
  endtask

  task automatic test_basic;
    run_single("basic", 1'b1, 8'hA5, 8'h3C, 25);
    vectors++;
    if (exp_q[0] !== 8'hA5) begin miscompares++; $display("FAIL basic_model got %h want a5", exp_q[0]); end
  endtask

  task automatic test_underrun;
    run_single("underrun", 1'b0, 8'h00, 8'h12, 10);
  endtask

  task automatic test_back_to_back;
    logic [7:0] want_rx[3];
    want_rx = '{8'hF0, 8'h0F, 8'h55};
    load(8'h01);
    mosi_q.delete();
    foreach (want_rx[i]) mosi_q.push_back(want_rx[i]);
    rx_q.delete();
    fork
      spi_xfer(3, 8, 0);
      begin load(8'h02); load(8'h03); end
    join
    vectors++;
    if (got_q.size() != 3 || rx_q.size() != 3) begin
      miscompares++;
      $display("FAIL burst_count got miso=%0d rx=%0d want 3/3", got_q.size(), rx_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors += 2;
        if (got_q[i] !== exp_q[i] || got_q[i] !== 8'(i + 1)) begin
          miscompares++; $display("FAIL burst_miso%0d got %h want %h", i, got_q[i], exp_q[i]);
        end
        if (rx_q[i] !== want_rx[i]) begin
          miscompares++; $display("FAIL burst_rx%0d got %h want %h", i, rx_q[i], want_rx[i]);
        end
      end
    end
  endtask

  task automatic test_abort;
    load(8'hC3);
    mosi_q.delete();
    mosi_q.push_back(8'hA7);
    rx_q.delete();
    fork
      spi_xfer(1, 8, 5);
      load(8'h96);
    join
    vectors += 2;
    if (rx_q.size() != 0) begin
      miscompares++; $display("FAIL abort_rx_valid got %0d pulses want 0", rx_q.size());
    end
    if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle got oe=%b miso=%b busy=%b want 0/1/0", spi_miso_oe, spi_miso, busy);
    end
    // Data loaded during the aborted word must survive into the next transfer.
    run_single("after_abort", 1'b0, 8'h00, 8'h5A, 8);
    vectors++;
    if (exp_q[0] !== 8'h96) begin miscompares++; $display("FAIL abort_model got %h want 96", exp_q[0]); end
  endtask

  task automatic test_reset_mid_word;
    load(8'h77);
    @(negedge clk50m);
    spi_ss = 1'b0;
    wait_cyc(8);
    repeat (3) begin
      spi_mosi = $urandom_range(0, 1);
      spi_sclk = 1'b1; wait_cyc(8);
      spi_sclk = 1'b0; wait_cyc(8);
    end
    spi_sclk = 1'b1;
    wait_cyc(3);
    rst_n = 1'b0;
    #1;
    test_reset;
    spi_sclk = 1'b0;
    spi_ss = 1'b1;
    hold_vld = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(5);
    run_single("post_reset", 1'b1, 8'h3E, 8'hC8, 9);
  endtask

  task automatic test_first_bit;
    logic [7:0] w;
    logic want;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    run_single("first_bit", 1'b1, 8'h01, 8'h80, 8);
    w = got_q.size() > 0 ? got_q[0] : 8'hxx;
    vectors++;
    if (w[bit_idx(0)] !== want) begin
      miscompares++; $display("FAIL first_bit got %b want %b", w[bit_idx(0)], want);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 8; k++) begin
      run_single("random", 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                 int'($urandom_range(6, 12)));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    wait_cyc(3);
    #1;
    test_reset;
    @(negedge clk50m);
    rst_n = 1'b1;
    wait_cyc(4);
    test_basic;
    test_underrun;
    test_back_to_back;
    test_abort;
    test_reset_mid_word;
    test_first_bit;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
